// File: rtl/serial_addsub_word.sv
// Word-framed bit-serial adder/subtractor: LSB-first operand streams in,
// registered sum bits out, parallel result with carry and signed overflow at word end.
module serial_addsub_word #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  output logic             sum,
  output logic             sum_valid,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic             mode;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] stage;

  logic             first_p0;
  logic             take_p0;
  logic             last_p0;
  logic             mode_p0;
  logic             cin_p0;
  logic             bx_p0;
  logic             s_p0;
  logic             c_next_p0;
  logic [WIDTH-1:0] stage_next_p0;

  // Processed bits enter from the MSB side so bit 0 lands at the LSB after WIDTH shifts.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] word,
                                                input logic bit_in);
    logic [WIDTH-1:0] t;
    t = word >> 1;
    t[WIDTH-1] = bit_in;
    return t;
  endfunction

  // Stage p0: bit arithmetic; in IDLE the live sub input is both mode and carry-in.
  always_comb begin
    first_p0      = (state == IDLE) && in_valid && start;
    take_p0       = first_p0 || ((state == RUN) && in_valid);
    mode_p0       = (state == IDLE) ? sub : mode;
    cin_p0        = (state == IDLE) ? sub : carry;
    bx_p0         = b ^ mode_p0;
    s_p0          = a ^ bx_p0 ^ cin_p0;
    c_next_p0     = (a & bx_p0) | (a & cin_p0) | (bx_p0 & cin_p0);
    last_p0       = 1'b0;
    if (take_p0) begin
      if (state == IDLE) last_p0 = (WIDTH == 1);
      else               last_p0 = (cnt == CW'(WIDTH - 1));
    end
    stage_next_p0 = shift_in(stage, s_p0);
  end

  // Stage p1: registered bit output, word state and parallel results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode      <= 1'b0;
      carry     <= 1'b0;
      cnt       <= '0;
      stage     <= '0;
      sum       <= 1'b0;
      sum_valid <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      sum_valid <= take_p0;
      done      <= last_p0;
      if (take_p0) begin
        sum   <= s_p0;
        carry <= c_next_p0;
        stage <= stage_next_p0;
      end
      case (state)
        IDLE: begin
          if (first_p0) begin
            mode  <= sub;
            cnt   <= CW'(1);
            state <= last_p0 ? IDLE : RUN;
          end
        end
        RUN: begin
          if (in_valid) begin
            cnt <= cnt + CW'(1);
            if (last_p0) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (last_p0) begin
        result    <= stage_next_p0;
        carry_out <= c_next_p0;
        overflow  <= cin_p0 ^ c_next_p0;
      end
    end
  end

  assign busy = (state == RUN);

endmodule
